ift_sram_pipe: RTL and testbench
================================

IFT_SRAM_PIPE -- requirements
Module: ift_sram_pipe

Interface
REQ-001 Parameter DATA_WIDTH, 64, data word width in bits; SHALL be a multiple of 8; NB = DATA_WIDTH/8.
REQ-002 Parameter NUM_WORDS, 32, depth; SHALL be a power of 2; AW = $clog2(NUM_WORDS).
REQ-003 Parameter NUM_FLAGS, 2, number of independent taint flags (shadow planes).
REQ-004 Parameter RD_LATENCY, 1, accepted-read to rvalid_o latency in cycles; legal range 1..4.
REQ-005 Clocking: one clock; reset is asynchronous and active-low.
REQ-006 clk_i  in  1  clock, all state on rising edge.
REQ-007 rst_ni  in  1  asynchronous active-low reset.
REQ-008 req_i  in  1  access request.
REQ-009 we_i  in  1  1 = write, 0 = read.
REQ-010 addr_i  in  AW  word address.
REQ-011 wdata_i  in  DATA_WIDTH  write data.
REQ-012 be_i  in  NB  byte enables.
REQ-013 gnt_o  out  1  request accepted this cycle when req_i & gnt_o.
REQ-014 rdata_o  out  DATA_WIDTH  read data.
REQ-015 rvalid_o  out  1  rdata_o/rdata_o_t valid, one-cycle pulse per read.
REQ-016 req_i_t, we_i_t  in  NUM_FLAGS each  per-flag taint of req_i, we_i.
REQ-017 addr_i_t  in  NUM_FLAGS x AW  per-flag address taint.
REQ-018 wdata_i_t  in  NUM_FLAGS x DATA_WIDTH  per-flag write-data taint.
REQ-019 be_i_t  in  NUM_FLAGS x NB  per-flag byte-enable taint.
REQ-020 rdata_o_t  out  NUM_FLAGS x DATA_WIDTH  per-flag read-data taint.
REQ-021 tclr_i  in  NUM_FLAGS  per-flag shadow-clear request (sampled only in IDLE).
REQ-022 scrub_busy_o  out  1  scrub FSM active.

Function
REQ-023 Storage SHALL be one data array plus NUM_FLAGS shadow arrays, each NUM_WORDS x DATA_WIDTH.
REQ-024 FSM states IDLE, SCRUB; gnt_o SHALL be 1 exactly in IDLE; requests while gnt_o=0 SHALL be dropped with no side effect.
REQ-025 IDLE -> SCRUB when tclr_i != 0; mask latched = tclr_i; index counter starts at 0.
REQ-026 SCRUB: each cycle zero word[index] in every masked shadow plane, index+1; at index = NUM_WORDS-1 return to IDLE next cycle (NUM_WORDS cycles busy); tclr_i ignored while in SCRUB.
REQ-027 Scrub SHALL NOT alter the data array, unmasked planes, or reads already in the pipeline.
REQ-028 Accepted write: for each byte b with be_i[b]=1, data byte <= wdata_i byte b.
REQ-029 Accepted write, per flag f, ctl_t[f] = |addr_i_t[f] | we_i_t[f] | req_i_t[f]; for each byte b with be_i[b] | be_i_t[f][b]: shadow_f byte b <= (be_i[b] ? wdata_i_t[f] byte b : old shadow_f byte b) | {8{ctl_t[f] | be_i_t[f][b]}}.
REQ-030 Accepted read: captures address and rtaint[f] = |addr_i_t[f] | req_i_t[f] | we_i_t[f]; array read after all writes accepted in earlier cycles.
REQ-031 Read result SHALL appear RD_LATENCY cycles after acceptance with rvalid_o=1; rdata_o_t[f] = shadow_f[addr] | {DATA_WIDTH{rtaint[f]}}.
REQ-032 Back-to-back reads SHALL be fully pipelined, one result per cycle, in order.
REQ-033 rdata_o and rdata_o_t SHALL hold last value when rvalid_o=0.
REQ-034 Write immediately after a read to the same address SHALL NOT change that read's result.

Reset
REQ-035 Reset asserted: rvalid_o=0, read pipeline valid bits cleared, rdata_o=0, rdata_o_t=0, gnt_o=0, scrub_busy_o=1, FSM=SCRUB, index=0, mask=all ones.
REQ-036 After release, the FSM SHALL scrub all planes (NUM_WORDS cycles) then enter IDLE; the data array is not reset.
REQ-037 Reset mid-read SHALL discard in-flight reads (no rvalid_o after release).

Verification (DATA_WIDTH=64, NUM_WORDS=32, NUM_FLAGS=2, RD_LATENCY=2)
REQ-038 Release reset -> gnt_o=0, scrub_busy_o=1 for exactly 32 cycles, then gnt_o=1, scrub_busy_o=0; any read returns rdata_o_t=0.
REQ-039 Write addr 5, wdata 0x1122334455667788, be 0x0F, wdata_i_t[0]=0xFF; read addr 5 -> rvalid_o 2 cycles after grant, rdata_o low 32 bits=0x55667788, rdata_o_t[0]=0xFF, rdata_o_t[1]=0.
REQ-040 Write addr 3, be 0x01, addr_i_t[1]=0x01, no data taint; read addr 3 -> rdata_o_t[1]=0xFF, rdata_o_t[0]=0.
REQ-041 Read addr 3 with addr_i_t[0]=0x04 -> rdata_o_t[0]=all ones, rdata_o_t[1] unchanged from stored.
REQ-042 tclr_i=2'b01 after REQ-039/040 -> 32 busy cycles, reads issued during them get no rvalid_o; then addr 5 t0=0, addr 3 t1=0xFF.
REQ-043 Accept read, assert rst_ni=0 one cycle later -> rvalid_o never pulses for that read; rdata_o=0.

Source files
------------

// File: rtl/ift_sram_pipe_if.sv
// Request/response bundle for ift_sram_pipe.
// Carries the data-path signals and their per-flag taint shadows.
interface ift_sram_pipe_if #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_WORDS  = 32,
  parameter int NUM_FLAGS  = 2
) ();
  localparam int NB = DATA_WIDTH / 8;
  localparam int AW = $clog2(NUM_WORDS);

  logic                                 req_i;
  logic                                 we_i;
  logic [AW-1:0]                        addr_i;
  logic [DATA_WIDTH-1:0]                wdata_i;
  logic [NB-1:0]                        be_i;
  logic                                 gnt_o;
  logic [DATA_WIDTH-1:0]                rdata_o;
  logic                                 rvalid_o;
  logic [NUM_FLAGS-1:0]                 req_i_t;
  logic [NUM_FLAGS-1:0]                 we_i_t;
  logic [NUM_FLAGS-1:0][AW-1:0]         addr_i_t;
  logic [NUM_FLAGS-1:0][DATA_WIDTH-1:0] wdata_i_t;
  logic [NUM_FLAGS-1:0][NB-1:0]         be_i_t;
  logic [NUM_FLAGS-1:0][DATA_WIDTH-1:0] rdata_o_t;
  logic [NUM_FLAGS-1:0]                 tclr_i;
  logic                                 scrub_busy_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i, be_i,
    output req_i_t, we_i_t, addr_i_t, wdata_i_t, be_i_t,
    output tclr_i,
    input  gnt_o, rdata_o, rvalid_o, rdata_o_t, scrub_busy_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, be_i,
    input  req_i_t, we_i_t, addr_i_t, wdata_i_t, be_i_t,
    input  tclr_i,
    output gnt_o, rdata_o, rvalid_o, rdata_o_t, scrub_busy_o
  );
endinterface

// File: rtl/ift_sram_pipe.sv
// Single-port SRAM with per-flag taint shadow planes,
// a pipelined read path and a shadow-scrub FSM.
module ift_sram_pipe #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_WORDS  = 32,
  parameter int NUM_FLAGS  = 2,
  parameter int RD_LATENCY = 1
) (
  input logic           clk_i,
  input logic           rst_ni,
  ift_sram_pipe_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int AW = $clog2(NUM_WORDS);
  localparam int L  = RD_LATENCY;

  typedef logic [NUM_FLAGS-1:0][DATA_WIDTH-1:0] taint_t;
  typedef enum logic {IDLE, SCRUB} state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [NUM_FLAGS-1:0] mask_q, mask_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SCRUB;
      idx_q   <= '0;
      mask_q  <= '1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.tclr_i) begin
          state_d = SCRUB;
          mask_d  = bus.tclr_i;
          idx_d   = '0;
        end
      end
      SCRUB: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == AW'(NUM_WORDS - 1)) state_d = IDLE;
      end
      default: state_d = SCRUB;
    endcase
  end

  logic acc, wr, rd;
  assign bus.gnt_o        = (state_q == IDLE);
  assign bus.scrub_busy_o = (state_q == SCRUB);
  assign acc = bus.req_i & bus.gnt_o;
  assign wr  = acc & bus.we_i;
  assign rd  = acc & ~bus.we_i;

  logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
  logic [DATA_WIDTH-1:0] shd_q [NUM_FLAGS][NUM_WORDS];
  logic [NUM_FLAGS-1:0]  ctl_t, rtaint;

  always_comb begin
    ctl_t  = '0;
    rtaint = '0;
    for (int f = 0; f < NUM_FLAGS; f++) begin
      ctl_t[f]  = |bus.addr_i_t[f] | bus.we_i_t[f] | bus.req_i_t[f];
      rtaint[f] = ctl_t[f];
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) begin
      for (int b = 0; b < NB; b++)
        if (bus.be_i[b])
          mem_q[bus.addr_i][b*8 +: 8] <= bus.wdata_i[b*8 +: 8];
    end
  end

  // Scrub and writes never coincide: writes need a grant, i.e. IDLE.
  always_ff @(posedge clk_i) begin
    for (int f = 0; f < NUM_FLAGS; f++) begin
      if (state_q == SCRUB && mask_q[f]) begin
        shd_q[f][idx_q] <= '0;
      end else if (wr) begin
        for (int b = 0; b < NB; b++)
          if (bus.be_i[b] | bus.be_i_t[f][b])
            shd_q[f][bus.addr_i][b*8 +: 8] <=
              (bus.be_i[b] ? bus.wdata_i_t[f][b*8 +: 8]
                           : shd_q[f][bus.addr_i][b*8 +: 8])
              | {8{ctl_t[f] | bus.be_i_t[f][b]}};
      end
    end
  end

  logic [DATA_WIDTH-1:0] rd_data;
  taint_t                rd_taint;

  always_comb begin
    rd_data  = mem_q[bus.addr_i];
    rd_taint = '0;
    for (int f = 0; f < NUM_FLAGS; f++)
      rd_taint[f] = shd_q[f][bus.addr_i] | {DATA_WIDTH{rtaint[f]}};
  end

  logic [L-1:0]          pv_q, sv;
  logic [DATA_WIDTH-1:0] pd_q [L];
  logic [DATA_WIDTH-1:0] sd   [L];
  taint_t                pt_q [L];
  taint_t                st   [L];

  // Arrays are sampled at acceptance, so later writes/scrubs cannot
  // disturb reads already in flight.
  always_comb begin
    sv[0] = rd;
    sd[0] = rd_data;
    st[0] = rd_taint;
    for (int i = 1; i < L; i++) begin
      sv[i] = pv_q[i-1];
      sd[i] = pd_q[i-1];
      st[i] = pt_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pv_q <= '0;
      for (int i = 0; i < L; i++) begin
        pd_q[i] <= '0;
        pt_q[i] <= '0;
      end
    end else begin
      pv_q <= sv;
      for (int i = 0; i < L; i++) begin
        if (sv[i]) begin
          pd_q[i] <= sd[i];
          pt_q[i] <= st[i];
        end
      end
    end
  end

  assign bus.rvalid_o  = pv_q[L-1];
  assign bus.rdata_o   = pd_q[L-1];
  assign bus.rdata_o_t = pt_q[L-1];
endmodule

// File: tb/tb_ift_sram_pipe.sv
// Directed self-checking bench for ift_sram_pipe
// (64-bit, 32 words, 2 flags, read latency 2).
module tb_ift_sram_pipe;
  localparam int DW = 64;
  localparam int NW = 32;
  localparam int NF = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ift_sram_pipe_if #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .NUM_FLAGS(NF)) bus ();

  ift_sram_pipe #(
    .DATA_WIDTH(DW), .NUM_WORDS(NW), .NUM_FLAGS(NF), .RD_LATENCY(2)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.req_i = 0; bus.we_i = 0; bus.addr_i = '0;
    bus.wdata_i = '0; bus.be_i = '0;
    bus.req_i_t = '0; bus.we_i_t = '0; bus.addr_i_t = '0;
    bus.wdata_i_t = '0; bus.be_i_t = '0; bus.tclr_i = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d,
                    input logic [7:0] be);
    bus.req_i = 1; bus.we_i = 1; bus.addr_i = a;
    bus.wdata_i = d; bus.be_i = be;
    @(negedge clk);
    idle();
  endtask

  task automatic rd(input logic [4:0] a, output logic [63:0] d,
                    output logic [1:0][63:0] t, output int lat);
    bus.req_i = 1; bus.we_i = 0; bus.addr_i = a;
    @(negedge clk);
    idle();
    lat = 1;
    while (!bus.rvalid_o && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    d = bus.rdata_o;
    t = bus.rdata_o_t;
  endtask

  logic [63:0]      d;
  logic [1:0][63:0] t;
  int               lat, cnt, rvc, gc;

  initial begin
    idle();
    #2 rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_rvalid", 64'(bus.rvalid_o), 64'd0);
    chk("rst_rdata", bus.rdata_o, 64'd0);
    chk("rst_rdata_t0", bus.rdata_o_t[0], 64'd0);
    chk("rst_rdata_t1", bus.rdata_o_t[1], 64'd0);
    chk("rst_gnt", 64'(bus.gnt_o), 64'd0);
    chk("rst_busy", 64'(bus.scrub_busy_o), 64'd1);

    rst_n = 1;
    cnt = 0; gc = 0;
    while (bus.scrub_busy_o && cnt < 100) begin
      gc += int'(bus.gnt_o);
      cnt++;
      @(negedge clk);
    end
    chk("init_busy_cycles", 64'(cnt), 64'd32);
    chk("init_gnt_during_busy", 64'(gc), 64'd0);
    chk("init_gnt_after", 64'(bus.gnt_o), 64'd1);
    chk("init_busy_after", 64'(bus.scrub_busy_o), 64'd0);

    rd(5'd7, d, t, lat);
    chk("init_rd_lat", 64'(lat), 64'd2);
    chk("init_rd_t0", t[0], 64'd0);
    chk("init_rd_t1", t[1], 64'd0);

    bus.wdata_i_t[0] = 64'hFF;
    wr(5'd5, 64'h1122334455667788, 8'h0F);
    rd(5'd5, d, t, lat);
    chk("a5_lat", 64'(lat), 64'd2);
    chk("a5_data_lo", {32'd0, d[31:0]}, 64'h55667788);
    chk("a5_t0", t[0], 64'hFF);
    chk("a5_t1", t[1], 64'd0);
    @(negedge clk);
    chk("rvalid_pulse", 64'(bus.rvalid_o), 64'd0);
    chk("hold_data_lo", {32'd0, bus.rdata_o[31:0]}, 64'h55667788);

    bus.addr_i_t[1] = 5'h01;
    wr(5'd3, 64'h00000000000000A5, 8'h01);
    rd(5'd3, d, t, lat);
    chk("a3_data_b0", {56'd0, d[7:0]}, 64'hA5);
    chk("a3_t1", t[1], 64'hFF);
    chk("a3_t0", t[0], 64'd0);

    bus.addr_i_t[0] = 5'h04;
    rd(5'd3, d, t, lat);
    chk("a3_rtaint_t0", t[0], '1);
    chk("a3_rtaint_t1", t[1], 64'hFF);

    bus.be_i_t[1] = 8'h80;
    wr(5'd9, 64'hDEAD, 8'h00);
    rd(5'd9, d, t, lat);
    chk("a9_bet_t1", t[1], 64'hFF00000000000000);
    chk("a9_bet_t0", t[0], 64'd0);

    bus.wdata_i_t[1] = 64'h0F;
    wr(5'd12, 64'h0123456789ABCDEF, 8'hFF);
    bus.req_i = 1; bus.we_i = 0; bus.addr_i = 5'd12;
    @(negedge clk);
    bus.we_i = 1; bus.wdata_i = '1; bus.be_i = 8'hFF;
    @(negedge clk);
    idle();
    chk("raw_rvalid", 64'(bus.rvalid_o), 64'd1);
    chk("raw_data", bus.rdata_o, 64'h0123456789ABCDEF);
    chk("raw_t1", bus.rdata_o_t[1], 64'h0F);
    rd(5'd12, d, t, lat);
    chk("raw_new_data", d, '1);
    chk("raw_new_t1", t[1], 64'd0);

    bus.req_i = 1; bus.addr_i = 5'd5;
    @(negedge clk);
    bus.addr_i = 5'd3;
    @(negedge clk);
    idle();
    chk("b2b_v0", 64'(bus.rvalid_o), 64'd1);
    chk("b2b_d0", {32'd0, bus.rdata_o[31:0]}, 64'h55667788);
    chk("b2b_t0_0", bus.rdata_o_t[0], 64'hFF);
    @(negedge clk);
    chk("b2b_v1", 64'(bus.rvalid_o), 64'd1);
    chk("b2b_d1", {56'd0, bus.rdata_o[7:0]}, 64'hA5);
    chk("b2b_t1_1", bus.rdata_o_t[1], 64'hFF);
    @(negedge clk);

    bus.tclr_i = 2'b01;
    @(negedge clk);
    idle();
    cnt = 0; rvc = 0; gc = 0;
    while (bus.scrub_busy_o && cnt < 100) begin
      rvc += int'(bus.rvalid_o);
      gc  += int'(bus.gnt_o);
      idle();
      if (cnt == 0) begin
        bus.req_i = 1; bus.addr_i = 5'd5; bus.tclr_i = 2'b10;
      end else if (cnt == 1) begin
        bus.req_i = 1; bus.we_i = 1; bus.addr_i = 5'd3;
        bus.be_i = 8'hFF; bus.addr_i_t[0] = 5'h1F;
      end
      cnt++;
      @(negedge clk);
    end
    idle();
    chk("scrub_cycles", 64'(cnt), 64'd32);
    chk("scrub_rvalid", 64'(rvc), 64'd0);
    chk("scrub_gnt", 64'(gc), 64'd0);
    repeat (3) @(negedge clk);
    chk("scrub_no_late_rvalid", 64'(bus.rvalid_o), 64'd0);
    rd(5'd5, d, t, lat);
    chk("post_a5_t0", t[0], 64'd0);
    chk("post_a5_data", {32'd0, d[31:0]}, 64'h55667788);
    rd(5'd3, d, t, lat);
    chk("post_a3_t1", t[1], 64'hFF);
    chk("post_a3_t0", t[0], 64'd0);
    chk("post_a3_data", {56'd0, d[7:0]}, 64'hA5);
    rd(5'd9, d, t, lat);
    chk("post_a9_t1", t[1], 64'hFF00000000000000);

    bus.req_i = 1; bus.addr_i = 5'd12;
    @(negedge clk);
    idle();
    rst_n = 0;
    #1;
    chk("mid_rst_rvalid", 64'(bus.rvalid_o), 64'd0);
    chk("mid_rst_rdata", bus.rdata_o, 64'd0);
    chk("mid_rst_gnt", 64'(bus.gnt_o), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    rvc = 0;
    for (int i = 0; i < 40; i++) begin
      rvc += int'(bus.rvalid_o);
      @(negedge clk);
    end
    chk("mid_rst_no_rvalid", 64'(rvc), 64'd0);
    chk("mid_rst_gnt_after", 64'(bus.gnt_o), 64'd1);
    rd(5'd5, d, t, lat);
    chk("rst_keeps_data", {32'd0, d[31:0]}, 64'h55667788);
    chk("rst_scrubs_t1", t[1], 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
